// File: rtl/ysyx_23060096_mc_npc.sv
// Multi-cycle RV32I/E core: FETCH -> WAIT -> EXEC, one instruction at a time,
// stopping in HALT on EBREAK or on any encoding it cannot execute.
module ysyx_23060096_mc_npc #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NREG     = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted,
  output logic [31:0] halt_code,
  output logic        trap
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;
  state_t state, state_n;

  logic [31:0] inst;
  logic [31:0] regs [NREG];

  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_b, imm_u, imm_j, rv1, rv2, wdata, npc;
  logic        legal, ebreak, wen, use1, use2, take, bad_idx, ok;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op, input logic alt);
    case (op)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  always_comb begin
    opc   = inst[6:0];
    rd    = inst[11:7];
    f3    = inst[14:12];
    rs1   = inst[19:15];
    rs2   = inst[24:20];
    f7    = inst[31:25];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    rv1   = (rs1 == 5'd0) ? 32'd0 : regs[rs1[AW-1:0]];
    rv2   = (rs2 == 5'd0) ? 32'd0 : regs[rs2[AW-1:0]];
    legal = 1'b0;
    ebreak = 1'b0;
    wen   = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    take  = 1'b0;
    wdata = 32'd0;
    npc   = pc + 32'd4;
    case (opc)
      7'b0110111: begin legal = 1'b1; wen = 1'b1; wdata = imm_u; end
      7'b0010111: begin legal = 1'b1; wen = 1'b1; wdata = pc + imm_u; end
      7'b1101111: begin legal = 1'b1; wen = 1'b1; wdata = pc + 32'd4; npc = pc + imm_j; end
      7'b1100111: begin
        legal = (f3 == 3'd0); wen = 1'b1; use1 = 1'b1;
        wdata = pc + 32'd4;
        npc   = (rv1 + imm_i) & ~32'd1;
      end
      7'b1100011: begin
        legal = (f3 != 3'd2) && (f3 != 3'd3); use1 = 1'b1; use2 = 1'b1;
        case (f3)
          3'd0:    take = (rv1 == rv2);
          3'd1:    take = (rv1 != rv2);
          3'd4:    take = ($signed(rv1) <  $signed(rv2));
          3'd5:    take = ($signed(rv1) >= $signed(rv2));
          3'd6:    take = (rv1 <  rv2);
          3'd7:    take = (rv1 >= rv2);
          default: take = 1'b0;
        endcase
        if (take) npc = pc + imm_b;
      end
      7'b0010011: begin
        case (f3)
          3'd1:    legal = (f7 == 7'h00);
          3'd5:    legal = (f7 == 7'h00) || (f7 == 7'h20);
          default: legal = 1'b1;
        endcase
        wen = 1'b1; use1 = 1'b1;
        // only the shift-right form reads inst[30] as the arithmetic select
        wdata = alu(rv1, imm_i, f3, (f3 == 3'd5) && inst[30]);
      end
      7'b0110011: begin
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        wen = 1'b1; use1 = 1'b1; use2 = 1'b1;
        wdata = alu(rv1, rv2, f3, inst[30]);
      end
      7'b1110011: begin legal = (inst == 32'h0010_0073); ebreak = legal; end
      default: ;
    endcase
    bad_idx = (NREG < 32) && ((use1 && rs1[4]) || (use2 && rs2[4]) || (wen && rd[4]));
    ok      = legal && !bad_idx && !npc[1];
  end

  always_comb begin
    state_n        = state;
    imem_req_valid = 1'b0;
    retire         = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_valid = !rst;
        if (imem_req_ready) state_n = S_WAIT;
      end
      S_WAIT:  if (imem_rsp_valid) state_n = S_EXEC;
      S_EXEC: begin
        retire  = ok;
        state_n = (ok && !ebreak) ? S_FETCH : S_HALT;
      end
      default: state_n = S_HALT;
    endcase
  end

  assign imem_req_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      inst      <= 32'd0;
      halted    <= 1'b0;
      trap      <= 1'b0;
      halt_code <= 32'd0;
    end else begin
      state <= state_n;
      if (state == S_WAIT && imem_rsp_valid) inst <= imem_rsp_data;
      if (state == S_EXEC) begin
        if (ok && !ebreak) pc <= npc;
        if (!ok || ebreak) begin
          halted    <= 1'b1;
          trap      <= !ok;
          halt_code <= regs[10];
        end
      end
    end
  end

  // register file is not reset; x0 is never written and reads as zero
  always_ff @(posedge clk) begin
    if (state == S_EXEC && ok && wen && rd != 5'd0) regs[rd[AW-1:0]] <= wdata;
  end
endmodule

// File: tb/tb_ysyx_23060096_mc_npc.sv
// Directed-program bench: an instruction-memory responder feeds the core, and a
// monitor checks every retire / halt event against a queue of expected events.
module tb_ysyx_23060096_mc_npc;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, sel16, rst32, rst16;
  logic r_ready, m_ready, r_rsp_valid, m_rsp_valid, resp_en, junk_en;
  logic [31:0] r_rsp_data, m_rsp_data;
  logic req_ready, rsp_valid;
  logic [31:0] rsp_data;
  int ready_dly, rsp_dly;
  int vecs = 0, errs = 0;

  assign rst32     = rst_a | sel16;
  assign rst16     = rst_a | ~sel16;
  assign req_ready = r_ready | m_ready;
  assign rsp_valid = r_rsp_valid | m_rsp_valid;
  assign rsp_data  = m_rsp_valid ? m_rsp_data : r_rsp_data;

  logic v32, v16, ret32, ret16, h32, h16, t32, t16;
  logic [31:0] ad32, ad16, pc32, pc16, hc32, hc16;

  ysyx_23060096_mc_npc #(.RESET_PC(BASE), .NREG(32)) dut (
    .clk(clk), .rst(rst32), .imem_req_valid(v32), .imem_req_ready(req_ready),
    .imem_req_addr(ad32), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .pc(pc32), .retire(ret32), .halted(h32), .halt_code(hc32), .trap(t32));

  ysyx_23060096_mc_npc #(.RESET_PC(BASE), .NREG(16)) dut16 (
    .clk(clk), .rst(rst16), .imem_req_valid(v16), .imem_req_ready(req_ready),
    .imem_req_addr(ad16), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .pc(pc16), .retire(ret16), .halted(h16), .halt_code(hc16), .trap(t16));

  logic a_req_valid, a_retire, a_halted, a_trap;
  logic [31:0] a_req_addr, a_pc, a_halt_code;
  assign a_req_valid = sel16 ? v16   : v32;
  assign a_req_addr  = sel16 ? ad16  : ad32;
  assign a_pc        = sel16 ? pc16  : pc32;
  assign a_retire    = sel16 ? ret16 : ret32;
  assign a_halted    = sel16 ? h16   : h32;
  assign a_halt_code = sel16 ? hc16  : hc32;
  assign a_trap      = sel16 ? t16   : t32;

  logic [31:0] mem [0:31];

  typedef struct {
    logic        is_halt;
    logic [31:0] pc;
    logic [31:0] code;
    logic        trap;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return mem[off[6:2]];
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], rs2[4:0], rs1[4:0], f3[2:0], b[4:1], b[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] j;
    j = imm[20:0];
    return {j[20], j[10:1], j[11], j[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic exp_ret(input int off);
    exp_t e;
    e.is_halt = 1'b0; e.pc = BASE + off; e.code = 32'd0; e.trap = 1'b0;
    sbq.push_back(e);
  endtask
  task automatic exp_halt(input int off, input logic [31:0] code, input logic tr);
    exp_t e;
    e.is_halt = 1'b1; e.pc = BASE + off; e.code = code; e.trap = tr;
    sbq.push_back(e);
  endtask

  // responder: optional ready stall and response delay, junk data when not valid
  initial begin
    logic [31:0] cap;
    r_ready = 1'b0; r_rsp_valid = 1'b0; r_rsp_data = EBRK;
    forever begin
      @(posedge clk); #1;
      if (resp_en && a_req_valid) begin
        cap = a_req_addr;
        for (int i = 0; i < ready_dly; i++) begin
          r_rsp_valid = junk_en;
          @(posedge clk); #1;
          check("addr_stable", a_req_addr, cap);
          check("req_held", {31'b0, a_req_valid}, 32'd1);
        end
        r_rsp_valid = 1'b0;
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
          @(posedge clk); #1;
          check("wait_req_low", {31'b0, a_req_valid}, 32'd0);
        end
        r_rsp_valid = 1'b1; r_rsp_data = mem_rd(cap);
        @(posedge clk); #1;
        r_rsp_valid = 1'b0; r_rsp_data = EBRK;
      end
    end
  end

  // monitor: every retire pulse and every halt rising edge consumes one entry
  initial begin
    logic hq;
    exp_t e;
    hq = 1'b0;
    forever begin
      @(negedge clk);
      if (a_retire || (a_halted && !hq)) begin
        if (sbq.size() == 0) begin
          vecs++; errs++;
          $display("FAIL unexpected_event: retire=%b halted=%b pc=%h", a_retire, a_halted, a_pc);
        end else begin
          e = sbq.pop_front();
          if (a_retire) begin
            check("retire_kind", 32'd0, {31'b0, e.is_halt});
            check("retire_pc", a_pc, e.pc);
          end else begin
            check("halt_kind", 32'd1, {31'b0, e.is_halt});
            check("halt_pc", a_pc, e.pc);
            check("halt_code", a_halt_code, e.code);
            check("halt_trap", {31'b0, a_trap}, {31'b0, e.trap});
          end
        end
      end
      hq = a_halted;
    end
  end

  task automatic do_reset(input logic use16);
    rst_a = 1'b1;
    sel16 = use16;
    repeat (2) @(negedge clk);
    check("rst_pc", a_pc, BASE);
    check("rst_req_valid", {31'b0, a_req_valid}, 32'd0);
    check("rst_halted", {31'b0, a_halted}, 32'd0);
    check("rst_trap", {31'b0, a_trap}, 32'd0);
    check("rst_halt_code", a_halt_code, 32'd0);
    check("rst_retire", {31'b0, a_retire}, 32'd0);
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    rst_a = 1'b0;
    @(negedge clk);
    check("first_req_valid", {31'b0, a_req_valid}, 32'd1);
    check("first_req_addr", a_req_addr, BASE);
  endtask

  task automatic run_wait(input string nm);
    int n;
    n = 0;
    while (!a_halted && n < 600) begin @(negedge clk); n++; end
    if (!a_halted) begin
      vecs++; errs++;
      $display("FAIL %s_timeout: halted=%b after %0d cycles", nm, a_halted, n);
    end
    @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      check("halt_no_req", {31'b0, a_req_valid}, 32'd0);
    end
    check("sb_empty", sbq.size(), 32'd0);
    sbq.delete();
  endtask

  initial begin
    rst_a = 1'b1; sel16 = 1'b0; m_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = 32'd0;
    resp_en = 1'b1; junk_en = 1'b0; ready_dly = 0; rsp_dly = 0;

    // ADDI chain with a negative immediate
    do_reset(1'b0);
    mem[0] = enc_i(5, 0, 0, 1, 7'b0010011);
    mem[1] = enc_i(-7, 1, 0, 1, 7'b0010011);
    mem[2] = enc_i(0, 1, 0, 10, 7'b0010011);
    mem[3] = EBRK;
    exp_ret(0); exp_ret(4); exp_ret(8); exp_ret(12);
    exp_halt(12, 32'hFFFF_FFFE, 1'b0);
    run_wait("addi");

    // stalled request and delayed response, junk rsp_valid while fetching
    do_reset(1'b0);
    ready_dly = 4; rsp_dly = 3; junk_en = 1'b1;
    mem[0] = enc_i(32'h55, 0, 0, 10, 7'b0010011);
    mem[1] = EBRK;
    exp_ret(0); exp_ret(4);
    exp_halt(4, 32'h0000_0055, 1'b0);
    run_wait("stall");
    ready_dly = 0; rsp_dly = 0; junk_en = 1'b0;

    // LUI + ADDI into a0, then EBREAK
    do_reset(1'b0);
    mem[0] = enc_u(32'h12345, 10, 7'b0110111);
    mem[1] = enc_i(32'h678, 10, 0, 10, 7'b0010011);
    mem[2] = EBRK;
    exp_ret(0); exp_ret(4); exp_ret(8);
    exp_halt(8, 32'h1234_5678, 1'b0);
    run_wait("lui");

    // JAL link, BLTU not taken, BLT taken backwards
    do_reset(1'b0);
    mem[0] = enc_i(-1, 0, 0, 1, 7'b0010011);
    mem[1] = enc_i(1, 0, 0, 2, 7'b0010011);
    mem[2] = enc_j(12, 10);
    mem[3] = enc_i(32'h100, 10, 0, 10, 7'b0010011);
    mem[4] = EBRK;
    mem[5] = enc_b(-8, 2, 1, 3'b110);
    mem[6] = enc_b(-8, 2, 1, 3'b100);
    exp_ret(0); exp_ret(4); exp_ret(8); exp_ret(20); exp_ret(24); exp_ret(16);
    exp_halt(16, 32'h8000_000C, 1'b0);
    run_wait("branch");

    // JALR with rd==rs1 and an odd offset
    do_reset(1'b0);
    mem[0] = enc_u(0, 5, 7'b0010111);
    mem[1] = enc_i(13, 5, 0, 5, 7'b1100111);
    mem[2] = EBRK;
    mem[3] = enc_i(0, 5, 0, 10, 7'b0010011);
    mem[4] = EBRK;
    exp_ret(0); exp_ret(4); exp_ret(12); exp_ret(16);
    exp_halt(16, 32'h8000_0008, 1'b0);
    run_wait("jalr");

    // R-type shifts use only the low 5 bits of rs2
    do_reset(1'b0);
    mem[0] = enc_i(-16, 0, 0, 1, 7'b0010011);
    mem[1] = enc_i(36, 0, 0, 2, 7'b0010011);
    mem[2] = enc_r(7'h20, 2, 1, 5, 3);
    mem[3] = enc_r(7'h00, 2, 1, 5, 4);
    mem[4] = enc_r(7'h00, 4, 3, 4, 10);
    mem[5] = enc_r(7'h20, 2, 10, 0, 10);
    mem[6] = EBRK;
    exp_ret(0); exp_ret(4); exp_ret(8); exp_ret(12); exp_ret(16); exp_ret(20); exp_ret(24);
    exp_halt(24, 32'hEFFF_FFDC, 1'b0);
    run_wait("rtype");

    // misaligned JAL target traps with pc on the JAL
    do_reset(1'b0);
    mem[0] = enc_i(3, 0, 0, 10, 7'b0010011);
    mem[1] = enc_j(6, 1);
    exp_ret(0);
    exp_halt(4, 32'h0000_0003, 1'b1);
    run_wait("misalign");

    // RV32E core rejects x17
    do_reset(1'b1);
    mem[0] = enc_i(9, 0, 0, 10, 7'b0010011);
    mem[1] = enc_r(7'h00, 2, 1, 0, 17);
    exp_ret(0);
    exp_halt(4, 32'h0000_0009, 1'b1);
    run_wait("rv32e");

    // reset during WAIT, then a stale response while fetching
    resp_en = 1'b0;
    do_reset(1'b0);
    mem[0] = enc_i(32'h42, 0, 0, 10, 7'b0010011);
    mem[1] = EBRK;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("mid_wait_req_low", {31'b0, a_req_valid}, 32'd0);
    rst_a = 1'b1;
    #1 check("mid_rst_pc", a_pc, BASE);
    @(negedge clk);
    rst_a = 1'b0;
    m_rsp_valid = 1'b1; m_rsp_data = EBRK;
    @(negedge clk);
    m_rsp_valid = 1'b0;
    check("stale_halted", {31'b0, a_halted}, 32'd0);
    check("stale_req_valid", {31'b0, a_req_valid}, 32'd1);
    check("stale_req_addr", a_req_addr, BASE);
    exp_ret(0); exp_ret(4);
    exp_halt(4, 32'h0000_0042, 1'b0);
    resp_en = 1'b1;
    run_wait("stale");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ysyx_23060096_mc_npc.md
YSYX_23060096_MC_NPC -- requirements
Module: ysyx_23060096_mc_npc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: PC value after reset.
REQ-002 SHALL have parameter NREG, default 32: GPR count; legal values 32 (RV32I) or 16 (RV32E).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, 32 bits: fetch address, equal to pc.
REQ-008 SHALL have port imem_rsp_valid, input, 1 bit: instruction word valid.
REQ-009 SHALL have port imem_rsp_data, input, 32 bits: instruction word.
REQ-010 SHALL have port pc, output, 32 bits: current program counter.
REQ-011 SHALL have port retire, output, 1 bit: one-cycle pulse per committed instruction.
REQ-012 SHALL have port halted, output, 1 bit: core stopped.
REQ-013 SHALL have port halt_code, output, 32 bits: x10 (a0) value captured at halt.
REQ-014 SHALL have port trap, output, 1 bit: halt was caused by an illegal instruction.

Function
REQ-015 SHALL implement FSM FETCH -> WAIT -> EXEC -> FETCH, plus a terminal state HALT.
REQ-016 FETCH SHALL drive imem_req_valid=1, holding imem_req_addr stable until imem_req_ready=1; the handshake cycle moves the FSM to WAIT.
REQ-017 WAIT SHALL drive imem_req_valid=0, latch imem_rsp_data into the instruction register when imem_rsp_valid=1, and move to EXEC.
REQ-018 imem_rsp_valid SHALL be ignored outside WAIT.
REQ-019 EXEC SHALL decode, compute, write the GPR, update pc, and pulse retire, all in one cycle; minimum latency is 3 cycles per instruction.
REQ-020 Supported instructions SHALL be LUI, AUIPC, JAL, JALR, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, all R-type ALU ops, BEQ/BNE/BLT/BGE/BLTU/BGEU, and EBREAK.
REQ-021 Arithmetic SHALL be 32-bit modulo 2^32; immediates are sign-extended per RV32I I/S/B/U/J formats.
REQ-022 Shift amount SHALL be the low 5 bits of the operand.
REQ-023 JALR target SHALL be (rs1+imm) with bit 0 cleared.
REQ-024 JAL/JALR SHALL write pc+4 to rd.
REQ-025 Non-control instructions SHALL set next pc = pc+4; a taken branch SHALL set next pc = pc+imm.
REQ-026 x0 SHALL read as 0; writes to x0 SHALL be discarded.
REQ-027 GPR reads SHALL be combinational; the write SHALL occur at the end of EXEC.
REQ-028 When JALR has rd==rs1, the target SHALL use the old rs1 value.
REQ-029 EBREAK in EXEC SHALL capture x10 into halt_code, pulse retire, set halted=1, leave pc unchanged, and enter HALT.
REQ-030 Any unsupported encoding (including inst[1:0]!=2'b11) SHALL enter HALT with trap=1 and no GPR write; retire SHALL stay 0 and pc SHALL be unchanged.
REQ-031 When NREG=16, any rs1, rs2 or rd index >=16 SHALL be treated as illegal per REQ-030.
REQ-032 HALT SHALL be absorbing: imem_req_valid=0, no state change until rst.
REQ-033 Misaligned jump or branch targets (bit 1 set) SHALL be treated as illegal per REQ-030, with pc holding the faulting instruction's address.

Reset
REQ-034 rst=1 SHALL immediately force state=FETCH, pc=RESET_PC, retire=0, halted=0, trap=0, halt_code=0, and imem_req_valid deasserted during reset.
REQ-035 GPR contents SHALL be undefined after reset, except x0=0.
REQ-036 rst asserted in WAIT SHALL discard the outstanding response; an imem_rsp_valid arriving after reset release while in FETCH SHALL be ignored.
REQ-037 After rst deasserts, the first imem_req_valid SHALL assert on the next cycle with addr=RESET_PC.

Verification
REQ-038 Reset, then stream ADDI x1,x0,5; ADDI x1,x1,-7 -> x1=32'hFFFF_FFFE, two retire pulses, pc=RESET_PC+8.
REQ-039 Hold imem_req_ready=0 for 4 cycles, then delay rsp by 3 cycles -> addr stable throughout, exactly one retire, no early latch.
REQ-040 LUI x10,0x12345; ADDI x10,x10,0x678; EBREAK -> halted=1, halt_code=32'h1234_5678, no further requests.
REQ-041 BLT x1,x2,-8 with x1=-1 and x2=1 -> branch taken, pc decreases by 8; the same BLTU -> not taken, pc+4.
REQ-042 NREG=16 and ADD x17,x1,x2 -> trap=1, halted=1, retire=0, pc unchanged.
REQ-043 rst pulsed mid-WAIT, then the stale rsp_valid arrives -> it is ignored and the fetch restarts at RESET_PC.
